// File: rtl/tcam_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cam_defs: shared TCAM types for the request front-end and the array.
//   cam_t / addr_t        key-data word and entry index
//   tcam_req_t            controller -> array request bundle
//   tcam_resp_t           array -> controller combinational response
//   tcam_op_t             SEARCH / READ / WRITE / INVALIDATE opcodes
//   tcam_ctrl_entry_t     one buffered request in the controller FIFO
//   ctrl_state_t          controller state (only RUN used without
//                         TCAM_CTRL_FLUSH_EN)
// ---------------------------------------------------------------------------
package cam_defs;

    localparam int CAM_KEY_W = 32;
    localparam int CAM_DEPTH = 16;
    localparam int CAM_AW    = $clog2(CAM_DEPTH);

    typedef logic [CAM_KEY_W-1:0] cam_t;
    typedef logic [CAM_AW-1:0]    addr_t;

    typedef enum logic [1:0] {
        TCAM_OP_SEARCH     = 2'b00,
        TCAM_OP_READ       = 2'b01,
        TCAM_OP_WRITE      = 2'b10,
        TCAM_OP_INVALIDATE = 2'b11
    } tcam_op_t;

    typedef struct packed {
        addr_t addr;
        logic  addr_vld;
        logic  we;
        cam_t  data;
        logic  data_vld;
        cam_t  mask;
    } tcam_req_t;

    typedef struct packed {
        addr_t addr;
        logic  addr_vld;
        cam_t  data;
        logic  data_vld;
    } tcam_resp_t;

    typedef struct packed {
        tcam_op_t op;
        addr_t    addr;
        cam_t     key;
        cam_t     mask;
    } tcam_ctrl_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_FLUSH = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/tcam_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// tcam_ctrl_fifo: synchronous FIFO of tcam_ctrl_entry_t with show-ahead head.
//   clk, rst         clock, synchronous active-high reset (pointers only)
//   i_push, i_data   write request; ignored when full
//   i_pop            read request; ignored when empty
//   o_data           current head entry
//   o_full, o_empty  occupancy flags
// ---------------------------------------------------------------------------
module tcam_ctrl_fifo
    import cam_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  tcam_ctrl_entry_t i_data,
    input  logic             i_pop,
    output tcam_ctrl_entry_t o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    tcam_ctrl_entry_t r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/tcam_ctrl.sv
// ---------------------------------------------------------------------------
// tcam_ctrl: request front-end for the TCAM array.
// Buffers SEARCH/READ/WRITE/INVALIDATE requests in a FIFO, issues one per
// cycle onto tcam_req, and registers the combinational tcam_resp into an
// in-order valid/ready response stream (accept@N, issue@N+1, rsp@N+2).
// Optional feature macro: TCAM_CTRL_FLUSH_EN adds flush/flush_busy and a
// RUN->DRAIN->FLUSH->RUN sequence that invalidates every entry.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_op/addr/key/mask     request payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_op/hit/index/data    response payload
//   tcam_req / tcam_resp     array interface
//   flush / flush_busy       [TCAM_CTRL_FLUSH_EN] flush pulse / in-progress
// ---------------------------------------------------------------------------
module tcam_ctrl
    import cam_defs::*;
#(
    parameter int KEY_WIDTH  = CAM_KEY_W,
    parameter int KEY_DEPTH  = CAM_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [$clog2(KEY_DEPTH)-1:0] req_addr,
    input  logic [KEY_WIDTH-1:0]         req_key,
    input  logic [KEY_WIDTH-1:0]         req_mask,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [1:0]                   rsp_op,
    output logic                         rsp_hit,
    output logic [$clog2(KEY_DEPTH)-1:0] rsp_index,
    output logic [KEY_WIDTH-1:0]         rsp_data,
    output tcam_req_t                    tcam_req,
    input  tcam_resp_t                   tcam_resp
`ifdef TCAM_CTRL_FLUSH_EN
    ,
    input  logic                         flush,
    output logic                         flush_busy
`endif
);

    tcam_ctrl_entry_t w_push_entry;
    tcam_ctrl_entry_t w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_issue;
    logic             w_accept_en;
    logic             w_issue_en;
    logic             w_flush_issue;

    logic             r_rsp_valid;
    tcam_op_t         r_rsp_op;
    logic             r_rsp_hit;
    addr_t            r_rsp_index;
    cam_t             r_rsp_data;

`ifdef TCAM_CTRL_FLUSH_EN
    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    addr_t       r_flush_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_idx <= (r_state == ST_FLUSH) ? r_flush_idx + 1'b1 : '0;
        end
    end

    // flush is only sampled in RUN, so a pulse while busy is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (flush) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty && !r_rsp_valid) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_idx == addr_t'(KEY_DEPTH-1)) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    assign w_accept_en   = (r_state == ST_RUN);
    assign w_issue_en    = (r_state != ST_FLUSH);
    assign w_flush_issue = !rst && (r_state == ST_FLUSH);
    assign flush_busy    = (r_state != ST_RUN);
`else
    assign w_accept_en   = 1'b1;
    assign w_issue_en    = 1'b1;
    assign w_flush_issue = 1'b0;
`endif

    assign req_ready = !rst && !w_full && w_accept_en;

    // Issue is gated by rst so no array write leaks out in a reset cycle.
    assign w_issue = !rst && !w_empty && w_issue_en && (!r_rsp_valid || rsp_ready);

    assign w_push_entry.op   = tcam_op_t'(req_op);
    assign w_push_entry.addr = addr_t'(req_addr);
    assign w_push_entry.key  = cam_t'(req_key);
    assign w_push_entry.mask = cam_t'(req_mask);

    tcam_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (req_valid && req_ready),
        .i_data  (w_push_entry),
        .i_pop   (w_issue),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Array request: all-zero outside issue cycles so nothing is written.
    always_comb begin
        tcam_req = '0;
        if (w_issue) begin
            case (w_head.op)
                TCAM_OP_SEARCH: begin
                    tcam_req.data = w_head.key;
                    tcam_req.mask = w_head.mask;
                end
                TCAM_OP_READ: begin
                    tcam_req.addr     = w_head.addr;
                    tcam_req.addr_vld = 1'b1;
                end
                TCAM_OP_WRITE: begin
                    tcam_req.addr     = w_head.addr;
                    tcam_req.addr_vld = 1'b1;
                    tcam_req.we       = 1'b1;
                    tcam_req.data     = w_head.key;
                    tcam_req.data_vld = 1'b1;
                end
                default: begin
                    tcam_req.addr     = w_head.addr;
                    tcam_req.addr_vld = 1'b1;
                    tcam_req.we       = 1'b1;
                end
            endcase
        end else if (w_flush_issue) begin
`ifdef TCAM_CTRL_FLUSH_EN
            tcam_req.addr     = r_flush_idx;
`endif
            tcam_req.addr_vld = 1'b1;
            tcam_req.we       = 1'b1;
        end
    end

    // Response slot: captured from the array in the issue cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= TCAM_OP_SEARCH;
            r_rsp_hit   <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_data  <= '0;
        end else if (w_issue) begin
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= w_head.op;
            if (w_head.op == TCAM_OP_SEARCH) begin
                r_rsp_hit   <= tcam_resp.addr_vld;
                r_rsp_index <= tcam_resp.addr_vld ? tcam_resp.addr : '0;
            end else begin
                r_rsp_hit   <= 1'b1;
                r_rsp_index <= w_head.addr;
            end
            r_rsp_data <= (w_head.op == TCAM_OP_READ && tcam_resp.data_vld) ? tcam_resp.data : '0;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_op    = r_rsp_op;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_index = r_rsp_index;
    assign rsp_data  = r_rsp_data;

endmodule
